matrix_key_scanner: RTL and testbench

Scans a 5-row x 7-column switch matrix by strobing one column at a time and sampling the five row sense lines, the reverse direction of our LED row/column multiplexed display path. It assembles a 35-bit raw frame per scan, debounces it over consecutive identical scans, and reports each newly pressed key as a one-cycle event with a row/column code. It sits beside the display driver and feeds key events to the control logic.

---
 rtl/matrix_key_scanner_pkg.sv | 41 ++++
 rtl/matrix_key_scanner_debounce.sv | 64 ++++++
 rtl/matrix_key_scanner.sv | 98 +++++++++
 tb/tb_matrix_key_scanner.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_key_scanner_pkg.sv
// Shared dimensions, scan state type and frame helpers for the key matrix scanner.
package matrix_pkg;

    localparam int unsigned NUM_ROWS = 5;
    localparam int unsigned NUM_COLS = 7;
    localparam int unsigned FRAME_W  = NUM_ROWS * NUM_COLS;
    localparam int unsigned CODE_W   = 6;
    localparam int unsigned COL_W    = 3;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        COMPARE
    } scan_state_t;

    function automatic logic [CODE_W-1:0] popcount(input logic [FRAME_W-1:0] v);
        logic [CODE_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < FRAME_W; i++) begin
            n = n + CODE_W'(v[i]);
        end
        return n;
    endfunction

    function automatic logic [CODE_W-1:0] lowest_index(input logic [FRAME_W-1:0] v);
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int unsigned i = FRAME_W; i > 0; i--) begin
            if (v[i-1]) idx = CODE_W'(i - 1);
        end
        return idx;
    endfunction

    function automatic logic [NUM_COLS-1:0] col_strobe(input logic [COL_W-1:0] col);
        logic [NUM_COLS-1:0] one;
        one = NUM_COLS'(1);
        return ~(one << col);
    endfunction

endpackage

// File: rtl/matrix_key_scanner_debounce.sv
// Debounces raw scan frames and turns newly pressed keys into single-cycle events.
module key_debounce
    import matrix_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               compare,
    input  logic [FRAME_W-1:0] raw,
    output logic [FRAME_W-1:0] key_frame,
    output logic               key_valid,
    output logic [CODE_W-1:0]  key_code,
    output logic               multi_key
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    logic [FRAME_W-1:0] prev_raw;
    logic [FRAME_W-1:0] new_press;
    logic [CNT_W-1:0]   stable_cnt;
    logic [CNT_W-1:0]   next_cnt;
    logic [CODE_W-1:0]  press_cnt;

    // Count saturates so a long-held frame keeps re-confirming without wrapping.
    always_comb begin
        next_cnt = CNT_W'(1);
        if (raw == prev_raw) begin
            if (stable_cnt >= CNT_W'(DEBOUNCE_SCANS)) next_cnt = CNT_W'(DEBOUNCE_SCANS);
            else next_cnt = stable_cnt + CNT_W'(1);
        end
    end

    assign new_press = raw & ~key_frame;
    assign press_cnt = popcount(new_press);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_raw   <= '0;
            stable_cnt <= '0;
            key_frame  <= '0;
            key_valid  <= 1'b0;
            key_code   <= '0;
            multi_key  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            multi_key <= 1'b0;
            if (compare) begin
                prev_raw   <= raw;
                stable_cnt <= next_cnt;
                if (next_cnt == CNT_W'(DEBOUNCE_SCANS)) begin
                    key_frame <= raw;
                    if (press_cnt == CODE_W'(1)) begin
                        key_valid <= 1'b1;
                        key_code  <= lowest_index(new_press);
                    end else if (press_cnt >= CODE_W'(2)) begin
                        multi_key <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/matrix_key_scanner.sv
// Column-strobed 5x7 switch matrix scanner feeding a debounced key event stage.
module matrix_key_scanner
    import matrix_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                scan_en,
    input  logic [NUM_ROWS-1:0] linha_in,
    output logic [NUM_COLS-1:0] acender_coluna,
    output logic [FRAME_W-1:0]  key_frame,
    output logic                key_valid,
    output logic [CODE_W-1:0]   key_code,
    output logic                multi_key
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);

    scan_state_t        state;
    logic [COL_W-1:0]   col;
    logic [SET_W-1:0]   settle_cnt;
    logic [FRAME_W-1:0] raw;
    logic               compare;

    assign compare = (state == COMPARE);

    // Strobe is registered alongside the state, so it is set on the transition edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            col            <= '0;
            settle_cnt     <= '0;
            raw            <= '0;
            acender_coluna <= '1;
        end else begin
            case (state)
                IDLE: begin
                    acender_coluna <= '1;
                    if (scan_en) begin
                        state          <= SETTLE;
                        col            <= '0;
                        settle_cnt     <= '0;
                        acender_coluna <= col_strobe('0);
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) state <= SAMPLE;
                    else settle_cnt <= settle_cnt + SET_W'(1);
                end
                SAMPLE: begin
                    for (int unsigned r = 0; r < NUM_ROWS; r++) begin
                        raw[r*NUM_COLS + 32'(col)] <= linha_in[r];
                    end
                    if (col == COL_W'(NUM_COLS - 1)) begin
                        state          <= COMPARE;
                        acender_coluna <= '1;
                    end else begin
                        state          <= SETTLE;
                        col            <= col + COL_W'(1);
                        settle_cnt     <= '0;
                        acender_coluna <= col_strobe(col + COL_W'(1));
                    end
                end
                COMPARE: begin
                    col        <= '0;
                    settle_cnt <= '0;
                    if (scan_en) begin
                        state          <= SETTLE;
                        acender_coluna <= col_strobe('0);
                    end else begin
                        state          <= IDLE;
                        acender_coluna <= '1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    acender_coluna <= '1;
                end
            endcase
        end
    end

    key_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .compare   (compare),
        .raw       (raw),
        .key_frame (key_frame),
        .key_valid (key_valid),
        .key_code  (key_code),
        .multi_key (multi_key)
    );

endmodule

// File: tb/tb_matrix_key_scanner.sv
// Directed bench for matrix_key_scanner: a switch-matrix model drives the rows, a scoreboard checks events.
module tb_matrix_key_scanner;

    logic        clk;
    logic        rst;
    logic        scan_en;
    logic [4:0]  linha_in;
    logic [6:0]  acender_coluna;
    logic [34:0] key_frame;
    logic        key_valid;
    logic [5:0]  key_code;
    logic        multi_key;

    logic [34:0] keys;

    typedef struct packed {
        logic       multi;
        logic [5:0] code;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    matrix_key_scanner #(
        .SETTLE_CYCLES (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .scan_en       (scan_en),
        .linha_in      (linha_in),
        .acender_coluna(acender_coluna),
        .key_frame     (key_frame),
        .key_valid     (key_valid),
        .key_code      (key_code),
        .multi_key     (multi_key)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Switch matrix: a closed switch pulls its row high while its column is strobed.
    always_comb begin
        linha_in = '0;
        for (int c = 0; c < 7; c++) begin
            if (!acender_coluna[c]) begin
                for (int r = 0; r < 5; r++) begin
                    linha_in[r] = linha_in[r] | keys[r*7 + c];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (key_valid === 1'b1 || multi_key === 1'b1) begin
            check("pulse_exclusive", {63'd0, key_valid & multi_key}, 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_event", {62'd0, key_valid, multi_key}, 64'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                check("event_kind_valid", {63'd0, key_valid}, {63'd0, ~e.multi});
                check("event_kind_multi", {63'd0, multi_key}, {63'd0, e.multi});
                check("event_code", {58'd0, key_code}, {58'd0, e.code});
            end
        end
    end

    // Ends on the negedge of the next COMPARE cycle (all strobes released while scanning).
    task automatic next_compare();
        int n;
        n = 0;
        @(negedge clk);
        while (acender_coluna !== 7'h7F && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("compare_timeout", 64'd1, 64'd0);
    endtask

    task automatic scans(input int n);
        for (int i = 0; i < n; i++) next_compare();
    endtask

    task automatic push_ev(input logic multi, input logic [5:0] code);
        ev_t e;
        e.multi = multi;
        e.code  = code;
        exp_q.push_back(e);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [6:0]  one;
        logic [6:0]  exp_col;
        logic [34:0] bit17;
        int          n;
        one   = 7'd1;
        bit17 = 35'd1 << 17;
        keys    = '0;
        rst     = 1'b1;
        scan_en = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_acender", {57'd0, acender_coluna}, 64'h7F);
        check("rst_frame", {29'd0, key_frame}, 64'd0);
        check("rst_valid", {63'd0, key_valid}, 64'd0);
        check("rst_multi", {63'd0, multi_key}, 64'd0);
        check("rst_code", {58'd0, key_code}, 64'd0);

        // Full scan pattern plus the first cycle of the next scan.
        rst     = 1'b0;
        scan_en = 1'b1;
        for (int i = 0; i <= 36; i++) begin
            @(negedge clk);
            if (i == 35) exp_col = 7'h7F;
            else exp_col = ~(one << ((i % 36) / 5));
            check($sformatf("scan_col_%0d", i), {57'd0, acender_coluna}, {57'd0, exp_col});
        end

        // Single key (2,3) reports once after three identical scans.
        next_compare();
        keys = bit17;
        push_ev(1'b0, 6'd17);
        scans(2);
        @(negedge clk);
        check("hold_no_early", {63'd0, key_valid}, 64'd0);
        scans(1);
        @(negedge clk);
        check("hold_valid", {63'd0, key_valid}, 64'd1);
        check("hold_code", {58'd0, key_code}, 64'd17);
        check("hold_frame", {29'd0, key_frame}, {29'd0, bit17});
        scans(3);
        keys = '0;
        scans(3);
        @(negedge clk);
        check("release_frame", {29'd0, key_frame}, 64'd0);

        // Key (1,0) bouncing every other scan never debounces.
        next_compare();
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 0) ? (35'd1 << 7) : '0;
            next_compare();
            check($sformatf("bounce_frame_%0d", i), {29'd0, key_frame}, 64'd0);
        end
        keys = '0;
        scans(3);

        // Two keys in one update: multi_key only, code keeps its old value.
        keys = (35'd1 << 0) | (35'd1 << 34);
        push_ev(1'b1, 6'd17);
        scans(3);
        @(negedge clk);
        check("multi_pulse", {63'd0, multi_key}, 64'd1);
        check("multi_no_valid", {63'd0, key_valid}, 64'd0);
        check("multi_frame", {29'd0, key_frame}, {29'd0, (35'd1 << 0) | (35'd1 << 34)});
        check("multi_code", {58'd0, key_code}, 64'd17);
        next_compare();
        keys = '0;
        scans(3);
        @(negedge clk);
        check("multi_release", {29'd0, key_frame}, 64'd0);

        // Re-press of (2,3) reports again.
        next_compare();
        keys = bit17;
        push_ev(1'b0, 6'd17);
        scans(3);
        @(negedge clk);
        check("repress_valid", {63'd0, key_valid}, 64'd1);
        check("repress_code", {58'd0, key_code}, 64'd17);

        // Reset during column 4 with the key still held.
        n = 0;
        while (acender_coluna !== 7'h6F && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("col4_reached", {63'd0, n >= 100}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_acender", {57'd0, acender_coluna}, 64'h7F);
        check("midrst_frame", {29'd0, key_frame}, 64'd0);
        check("midrst_code", {58'd0, key_code}, 64'd0);
        rst = 1'b0;
        push_ev(1'b0, 6'd17);
        @(negedge clk);
        check("restart_col0", {57'd0, acender_coluna}, 64'h7E);
        scans(2);
        @(negedge clk);
        check("restart_no_early", {63'd0, key_valid}, 64'd0);
        scans(1);
        @(negedge clk);
        check("restart_valid", {63'd0, key_valid}, 64'd1);
        check("restart_frame", {29'd0, key_frame}, {29'd0, bit17});

        // scan_en dropped mid-scan: the scan completes, then the strobes stay released.
        repeat (7) @(negedge clk);
        scan_en = 1'b0;
        next_compare();
        repeat (40) @(negedge clk);
        check("idle_acender", {57'd0, acender_coluna}, 64'h7F);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
